opc5ls_mem_arbiter: RTL and testbench
=====================================

Name: opc5ls_mem_arbiter

Overview:
Shares one external memory port between the opc5ls CPU and a DMA requester (video/loader engine). Stalls the CPU through its clock-enable while memory is busy and applies a programmable number of wait states per access. Round-robin arbitration between the two requesters when both are pending. Sits between the CPU bus pins and the board SRAM/BRAM.

Parameters:
WAIT_STATES, 1, extra memory cycles per access, legal range 0..15; an access holds mem_ce for WAIT_STATES+1 cycles
AW, 16, address width
DW, 16, data width

Ports:
clk  in  1  single system clock, all logic on its rising edge
reset  in  1  synchronous reset, active-high
cpu_mreq_b  in  1  CPU memory request, active-low
cpu_rnw  in  1  CPU read(1)/write(0)
cpu_address  in  AW  CPU address
cpu_dout  in  DW  CPU write data
cpu_din  out  DW  read data to CPU, registered
cpu_clken  out  1  CPU clock enable
dma_req  in  1  DMA request, held high until dma_ack
dma_rnw  in  1  DMA read(1)/write(0)
dma_address  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_rdata  out  DW  DMA read data, registered
dma_ack  out  1  one-cycle completion pulse
mem_address  out  AW  memory address, registered
mem_wdata  out  DW  memory write data, registered
mem_rdata  in  DW  memory read data, valid in last mem_ce cycle
mem_ce  out  1  memory cycle active
mem_we  out  1  memory write strobe

Behaviour:
- Reset: state IDLE, last_grant=DMA (CPU wins first tie), wait counter 0; cpu_din, dma_rdata, mem_address, mem_wdata = 0; mem_ce, mem_we, dma_ack = 0. cpu_clken = 1 while reset is high, so the CPU can sample its own reset.
- States: IDLE, CPU_ACC, CPU_DONE, DMA_ACC, DMA_DONE.
- IDLE: cpu_req = !cpu_mreq_b; dma_pend = dma_req.
  - Only one pending: grant it.
  - Both pending: grant the side not equal to last_grant.
  - On grant: latch address, write data and rnw into mem_* registers; load counter = WAIT_STATES; update last_grant; go to CPU_ACC or DMA_ACC.
- *_ACC: mem_ce=1; mem_we = !latched_rnw for every ACC cycle.
  - counter != 0: decrement and stay.
  - counter == 0 (final cycle): capture mem_rdata into cpu_din or dma_rdata (reads only; writes leave it unchanged); go to the matching *_DONE state.
- CPU_DONE: mem_ce=0, cpu_clken=1 for exactly one cycle, next state IDLE. No re-grant in this cycle; the CPU's next bus request is sampled in IDLE.
- DMA_DONE: dma_ack=1 for exactly one cycle, next state IDLE. dma_req is ignored this cycle, so a held request is never granted twice.
- cpu_clken (combinational):
  - 1 in CPU_DONE.
  - 1 in any state other than CPU_ACC when cpu_mreq_b=1, so non-memory CPU cycles (EA_ED, INT) proceed during DMA transfers.
  - 0 otherwise: the CPU is stalled while its request is pending or being serviced.
- Latency: CPU memory cycle = WAIT_STATES+3 clocks from request seen in IDLE to the clken pulse. DMA = WAIT_STATES+3 clocks from grant to dma_ack.
- Worst-case CPU stall with DMA contention: 2*(WAIT_STATES+3) clocks. Round-robin guarantees no starvation.
- CPU inputs are sampled only in IDLE; they are stable during a stall because cpu_clken=0.
- Reset mid-access: the next edge forces IDLE and clears mem_ce/mem_we. The in-flight access is abandoned with no dma_ack and no cpu_din update. last_grant returns to DMA.
- Counter is 4 bits. WAIT_STATES=0 gives a single ACC cycle.

Test Plan:
- WAIT_STATES=1, CPU read 0x0010, mem returns 0xBEEF → cpu_clken low 3 cycles, then high 1 cycle with cpu_din=0xBEEF; mem_ce high exactly 2 cycles; mem_address=0x0010.
- CPU write 0x1234 to 0x0020 → mem_we and mem_ce high 2 cycles with mem_address=0x0020, mem_wdata=0x1234; cpu_din unchanged.
- After reset, CPU and DMA request in the same cycle, both re-requesting continuously → grant order CPU, DMA, CPU, DMA. Each dma_ack is a single-cycle pulse, and the DMA is never serviced twice per request.
- DMA read 0x8000 (mem 0x5A5A) while cpu_mreq_b=1 → cpu_clken stays 1 throughout; dma_ack pulses once with dma_rdata=0x5A5A.
- Reset asserted during 2nd CPU_ACC cycle → next cycle mem_ce=0, mem_we=0, cpu_clken=1, no dma_ack; the next CPU request is granted normally.
- WAIT_STATES=0, back-to-back CPU reads → mem_ce high 1 cycle per access, 3-cycle period; WAIT_STATES=15 → 16 ce cycles, counter wraps correctly.

Source files
------------

// File: rtl/opc5ls_mem_arbiter.sv
// opc5ls_mem_arbiter
// Shares one external memory port between the opc5ls CPU and a DMA requester.
// The CPU is stalled through cpu_clken while its access is pending or in
// flight. Every access holds mem_ce for WAIT_STATES+1 cycles. When both
// requesters are pending, round-robin arbitration picks the side that was not
// granted last.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   cpu_mreq_b/rnw      - CPU bus request (active-low) and direction
//   cpu_address/dout    - CPU address and write data
//   cpu_din             - registered read data returned to the CPU
//   cpu_clken           - CPU clock enable (low = stall)
//   dma_req/rnw         - DMA request (held until dma_ack) and direction
//   dma_address/wdata   - DMA address and write data
//   dma_rdata           - registered read data returned to the DMA engine
//   dma_ack             - one-cycle completion pulse for the DMA engine
//   mem_address/wdata   - registered memory address and write data
//   mem_rdata           - memory read data, valid in the last mem_ce cycle
//   mem_ce, mem_we      - memory cycle active / write strobe
module opc5ls_mem_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int AW          = 16,
  parameter int DW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_mreq_b,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_clken,
  input  logic          dma_req,
  input  logic          dma_rnw,
  input  logic [AW-1:0] dma_address,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_ce,
  output logic          mem_we
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_ACC  = 3'd1,
    CPU_DONE = 3'd2,
    DMA_ACC  = 3'd3,
    DMA_DONE = 3'd4
  } state_t;

  // Counter reload value; the counter is 4 bits wide, so 0..15 is the legal range.
  localparam logic [3:0] WAIT_LOAD = WAIT_STATES[3:0];

  state_t        state_reg, state_next;
  logic          last_dma_reg, last_dma_next;   // 1 = DMA was granted last
  logic [3:0]    count_reg, count_next;
  logic          rnw_reg, rnw_next;
  logic [AW-1:0] mem_address_reg, mem_address_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DW-1:0] cpu_din_reg, cpu_din_next;
  logic [DW-1:0] dma_rdata_reg, dma_rdata_next;

  logic cpu_req;
  logic grant_cpu;
  logic grant_dma;
  logic in_acc;

  assign cpu_req = !cpu_mreq_b;

  // A tie goes to whichever side did not win the previous grant.
  assign grant_cpu = cpu_req && (!dma_req || last_dma_reg);
  assign grant_dma = dma_req && (!cpu_req || !last_dma_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      last_dma_reg    <= 1'b1;
      count_reg       <= 4'd0;
      rnw_reg         <= 1'b1;
      mem_address_reg <= '0;
      mem_wdata_reg   <= '0;
      cpu_din_reg     <= '0;
      dma_rdata_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      last_dma_reg    <= last_dma_next;
      count_reg       <= count_next;
      rnw_reg         <= rnw_next;
      mem_address_reg <= mem_address_next;
      mem_wdata_reg   <= mem_wdata_next;
      cpu_din_reg     <= cpu_din_next;
      dma_rdata_reg   <= dma_rdata_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    last_dma_next    = last_dma_reg;
    count_next       = count_reg;
    rnw_next         = rnw_reg;
    mem_address_next = mem_address_reg;
    mem_wdata_next   = mem_wdata_reg;
    cpu_din_next     = cpu_din_reg;
    dma_rdata_next   = dma_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (grant_cpu) begin
          state_next       = CPU_ACC;
          last_dma_next    = 1'b0;
          count_next       = WAIT_LOAD;
          rnw_next         = cpu_rnw;
          mem_address_next = cpu_address;
          mem_wdata_next   = cpu_dout;
        end else if (grant_dma) begin
          state_next       = DMA_ACC;
          last_dma_next    = 1'b1;
          count_next       = WAIT_LOAD;
          rnw_next         = dma_rnw;
          mem_address_next = dma_address;
          mem_wdata_next   = dma_wdata;
        end
      end

      CPU_ACC: begin
        if (count_reg != 4'd0) begin
          count_next = count_reg - 4'd1;
        end else begin
          // Final memory cycle: read data is valid now.
          if (rnw_reg) begin
            cpu_din_next = mem_rdata;
          end
          state_next = CPU_DONE;
        end
      end

      DMA_ACC: begin
        if (count_reg != 4'd0) begin
          count_next = count_reg - 4'd1;
        end else begin
          if (rnw_reg) begin
            dma_rdata_next = mem_rdata;
          end
          state_next = DMA_DONE;
        end
      end

      // Both completion states return to IDLE without looking at requests,
      // so the CPU re-presents its bus cycle and a held dma_req is not
      // serviced twice.
      CPU_DONE: state_next = IDLE;
      DMA_DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign in_acc = (state_reg == CPU_ACC) || (state_reg == DMA_ACC);

  assign mem_ce      = in_acc;
  assign mem_we      = in_acc && !rnw_reg;
  assign dma_ack     = (state_reg == DMA_DONE);
  assign mem_address = mem_address_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign cpu_din     = cpu_din_reg;
  assign dma_rdata   = dma_rdata_reg;

  // The CPU runs while in reset (it must see its own reset), on the completion
  // pulse, and on any non-memory cycle unless its own access is in progress.
  assign cpu_clken = reset
                  || (state_reg == CPU_DONE)
                  || ((state_reg != CPU_ACC) && cpu_mreq_b);

endmodule

// File: tb/tb_opc5ls_mem_arbiter.sv
// Directed bench for opc5ls_mem_arbiter. Three instances are built with
// WAIT_STATES = 1, 0 and 15; instance 0 carries the arbitration, DMA and
// reset tests, instances 1 and 2 the wait-state boundary tests.
module tb_opc5ls_mem_arbiter;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset       [ND];
  logic        cpu_mreq_b  [ND];
  logic        cpu_rnw     [ND];
  logic [15:0] cpu_address [ND];
  logic [15:0] cpu_dout    [ND];
  logic [15:0] cpu_din     [ND];
  logic        cpu_clken   [ND];
  logic        dma_req     [ND];
  logic        dma_rnw     [ND];
  logic [15:0] dma_address [ND];
  logic [15:0] dma_wdata   [ND];
  logic [15:0] dma_rdata   [ND];
  logic        dma_ack     [ND];
  logic [15:0] mem_address [ND];
  logic [15:0] mem_wdata   [ND];
  logic [15:0] mem_rdata   [ND];
  logic        mem_ce      [ND];
  logic        mem_we      [ND];

  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
      opc5ls_mem_arbiter #(
        .WAIT_STATES((gi == 0) ? 1 : ((gi == 1) ? 0 : 15)),
        .AW(16),
        .DW(16)
      ) u_dut (
        .clk        (clk),
        .reset      (reset[gi]),
        .cpu_mreq_b (cpu_mreq_b[gi]),
        .cpu_rnw    (cpu_rnw[gi]),
        .cpu_address(cpu_address[gi]),
        .cpu_dout   (cpu_dout[gi]),
        .cpu_din    (cpu_din[gi]),
        .cpu_clken  (cpu_clken[gi]),
        .dma_req    (dma_req[gi]),
        .dma_rnw    (dma_rnw[gi]),
        .dma_address(dma_address[gi]),
        .dma_wdata  (dma_wdata[gi]),
        .dma_rdata  (dma_rdata[gi]),
        .dma_ack    (dma_ack[gi]),
        .mem_address(mem_address[gi]),
        .mem_wdata  (mem_wdata[gi]),
        .mem_rdata  (mem_rdata[gi]),
        .mem_ce     (mem_ce[gi]),
        .mem_we     (mem_we[gi])
      );
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One CPU bus cycle on instance d. Counts stalled cycles and mem_ce/mem_we
  // cycles until the clken pulse, then checks data and address.
  task automatic cpu_access(input int d, input bit rnw, input logic [15:0] addr,
                            input logic [15:0] wd, input logic [15:0] rd,
                            input int exp_low, input int exp_ce,
                            input bit release_req, output time t_done);
    logic [15:0] prev;
    int low, ce, we, n;
    @(posedge clk); #1;
    cpu_mreq_b[d]  = 1'b0;
    cpu_rnw[d]     = rnw;
    cpu_address[d] = addr;
    cpu_dout[d]    = wd;
    mem_rdata[d]   = rd;
    prev = cpu_din[d];
    low = 0; ce = 0; we = 0; n = 0;
    forever begin
      @(negedge clk);
      if (cpu_clken[d]) break;
      low++;
      if (mem_ce[d]) ce++;
      if (mem_we[d]) we++;
      n++;
      if (n > 64) break;
    end
    t_done = $time;
    $display("txn dut%0d cpu %s addr=%h low=%0d ce=%0d we=%0d din=%h",
             d, rnw ? "rd" : "wr", addr, low, ce, we, cpu_din[d]);
    check("cpu_clken_low", low, exp_low);
    check("mem_ce_cycles", ce, exp_ce);
    check("mem_we_cycles", we, rnw ? 0 : exp_ce);
    check("mem_address", {16'h0, mem_address[d]}, {16'h0, addr});
    if (!rnw) check("mem_wdata", {16'h0, mem_wdata[d]}, {16'h0, wd});
    check("cpu_din", {16'h0, cpu_din[d]}, {16'h0, rnw ? rd : prev});
    if (release_req) begin
      @(posedge clk); #1;
      cpu_mreq_b[d] = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1, t2;
    int low, acks, first_ack, ce, ng, pulses, dbl;
    logic prev_ce, prev_ack;
    logic [15:0] grants [8];

    for (int d = 0; d < ND; d++) begin
      reset[d] = 1'b1; cpu_mreq_b[d] = 1'b1; cpu_rnw[d] = 1'b1;
      cpu_address[d] = '0; cpu_dout[d] = '0;
      dma_req[d] = 1'b0; dma_rnw[d] = 1'b1; dma_address[d] = '0; dma_wdata[d] = '0;
      mem_rdata[d] = '0;
    end
    cpu_mreq_b[0] = 1'b0;   // clken must still be high because reset is asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_clken", cpu_clken[0], 1);
    check("reset_ce", mem_ce[0], 0);
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) reset[d] = 1'b0;
    cpu_mreq_b[0] = 1'b1;
    @(negedge clk);
    check("rst_cpu_din", cpu_din[0], 0);
    check("rst_dma_rdata", dma_rdata[0], 0);
    check("rst_mem_address", mem_address[0], 0);
    check("rst_mem_wdata", mem_wdata[0], 0);
    check("rst_mem_we", mem_we[0], 0);
    check("rst_dma_ack", dma_ack[0], 0);
    check("idle_clken", cpu_clken[0], 1);
    $display("txn dut0 reset state checked");

    // CPU read and write with WAIT_STATES=1
    cpu_access(0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 3, 2, 1'b1, t1);
    cpu_access(0, 1'b0, 16'h0020, 16'h1234, 16'h0000, 3, 2, 1'b1, t1);

    // DMA read while the CPU does non-memory cycles
    @(posedge clk); #1;
    dma_req[0] = 1'b1; dma_rnw[0] = 1'b1; dma_address[0] = 16'h8000;
    mem_rdata[0] = 16'h5A5A;
    low = 0; acks = 0; first_ack = 0; ce = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!cpu_clken[0]) low++;
      if (mem_ce[0]) ce++;
      if (dma_ack[0]) begin
        acks++;
        if (first_ack == 0) first_ack = i;
      end
      @(posedge clk); #1;
      if (acks > 0) dma_req[0] = 1'b0;
    end
    $display("txn dut0 dma rd addr=8000 ack_cycle=%0d acks=%0d rdata=%h", first_ack, acks, dma_rdata[0]);
    check("dma_clken_low", low, 0);
    check("dma_ce_cycles", ce, 2);
    check("dma_acks", acks, 1);
    check("dma_ack_latency", first_ack, 4);
    check("dma_rdata", dma_rdata[0], 16'h5A5A);
    check("dma_mem_address", mem_address[0], 16'h8000);

    // Round robin after reset: both requesters pending continuously
    @(posedge clk); #1; reset[0] = 1'b1;
    @(posedge clk); #1; reset[0] = 1'b0;
    cpu_mreq_b[0] = 1'b0; cpu_rnw[0] = 1'b1; cpu_address[0] = 16'h0100;
    dma_req[0] = 1'b1; dma_rnw[0] = 1'b1; dma_address[0] = 16'h0200;
    mem_rdata[0] = 16'h1111;
    ng = 0; acks = 0; pulses = 0; dbl = 0; prev_ce = 1'b0; prev_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (mem_ce[0] && !prev_ce && ng < 8) begin
        grants[ng] = mem_address[0];
        ng++;
      end
      if (dma_ack[0]) acks++;
      if (dma_ack[0] && prev_ack) dbl++;
      if (cpu_clken[0]) pulses++;
      prev_ce = mem_ce[0];
      prev_ack = dma_ack[0];
    end
    @(posedge clk); #1;
    cpu_mreq_b[0] = 1'b1; dma_req[0] = 1'b0;
    $display("txn dut0 round-robin grants=%0d acks=%0d clken_pulses=%0d", ng, acks, pulses);
    check("rr_grants", ng, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), grants[i], (i % 2 == 0) ? 16'h0100 : 16'h0200);
    check("rr_acks", acks, 2);
    check("rr_ack_double", dbl, 0);
    check("rr_clken_pulses", pulses, 2);
    check("rr_cpu_din", cpu_din[0], 16'h1111);
    check("rr_dma_rdata", dma_rdata[0], 16'h1111);

    // Reset during the second CPU_ACC cycle of a write
    @(posedge clk); #1;
    cpu_mreq_b[0] = 1'b0; cpu_rnw[0] = 1'b0; cpu_address[0] = 16'h0030; cpu_dout[0] = 16'hAAAA;
    @(negedge clk);            // IDLE
    @(negedge clk);            // first ACC cycle
    @(posedge clk); #1;        // now in second ACC cycle
    reset[0] = 1'b1; cpu_mreq_b[0] = 1'b1;
    @(negedge clk);
    check("midrst_we_before", mem_we[0], 1);
    @(posedge clk); #1; reset[0] = 1'b0;
    @(negedge clk);
    $display("txn dut0 reset mid-access ce=%b we=%b clken=%b ack=%b", mem_ce[0], mem_we[0], cpu_clken[0], dma_ack[0]);
    check("midrst_ce", mem_ce[0], 0);
    check("midrst_we", mem_we[0], 0);
    check("midrst_clken", cpu_clken[0], 1);
    check("midrst_ack", dma_ack[0], 0);
    check("midrst_cpu_din", cpu_din[0], 0);
    cpu_access(0, 1'b1, 16'h0040, 16'h0000, 16'h4321, 3, 2, 1'b1, t1);

    // WAIT_STATES=0: back-to-back reads, 3-cycle period
    cpu_access(1, 1'b1, 16'h0050, 16'h0000, 16'h0A0A, 2, 1, 1'b0, t1);
    cpu_access(1, 1'b1, 16'h0051, 16'h0000, 16'h0B0B, 2, 1, 1'b1, t2);
    check("ws0_period", 32'((t2 - t1) / 10), 3);

    // WAIT_STATES=15: counter starts at 15, two accesses to confirm reload
    cpu_access(2, 1'b1, 16'h0060, 16'h0000, 16'hC0DE, 17, 16, 1'b1, t1);
    cpu_access(2, 1'b0, 16'h0061, 16'h5555, 16'h0000, 17, 16, 1'b1, t1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
